// File: rtl/alu_mc_pkg.sv
// Shared opcode constants and controller state encoding for the multi-cycle ALU.
package alu_mc_pkg;

    localparam int NB_OP_DEF = 6;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DEF-1:0] OP_SLT = 6'b101010;
    localparam logic [NB_OP_DEF-1:0] OP_MUL = 6'b011000;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative signed multiplier: shift-add on operand magnitudes, one partial
// product per cycle, sign applied on the final step.
module alu_mul_seq #(
    parameter int NB_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_product,
    output logic               o_overflow
);

    localparam int MSB     = NB_DATA - 1;
    localparam int NB_PROD = 2 * NB_DATA;
    localparam int NB_CNT  = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] LAST_STEP = NB_CNT'(NB_DATA - 1);

    logic                busy_q, busy_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic [NB_PROD-1:0]  mcand_q, mcand_d;
    logic [NB_DATA-1:0]  mplier_q, mplier_d;
    logic [NB_PROD-1:0]  acc_q, acc_d;
    logic                neg_q, neg_d;

    logic [NB_DATA-1:0]  magA, magB;
    logic [NB_PROD-1:0]  accNext, signedProd;
    logic [NB_DATA:0]    prodUpper;

    // The most negative operand's magnitude still fits as an unsigned NB_DATA value.
    assign magA = i_data_a[MSB] ? (~i_data_a + 1'b1) : i_data_a;
    assign magB = i_data_b[MSB] ? (~i_data_b + 1'b1) : i_data_b;

    always_comb begin
        accNext    = acc_q + (mplier_q[0] ? mcand_q : '0);
        signedProd = neg_q ? (~accNext + 1'b1) : accNext;
        prodUpper  = signedProd[NB_PROD-1:MSB];
        o_done     = busy_q && (cnt_q == LAST_STEP);
        o_product  = signedProd[MSB:0];
        o_overflow = !((&prodUpper) || !(|prodUpper));
    end

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        if (i_start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{NB_DATA{1'b0}}, magA};
            mplier_d = magB;
            acc_d    = '0;
            neg_d    = i_data_a[MSB] ^ i_data_b[MSB];
        end else if (busy_q) begin
            acc_d    = accNext;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready operand capture, single-cycle ops retired next
// cycle, MUL handed to the iterative multiplier while the front end stalls.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_operation_code,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_overflow,
    output logic               o_zero,
    output logic               o_negative
);

    localparam int MSB = NB_DATA - 1;
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    state_e              state_q, state_d;
    logic                valid_q;
    logic [NB_DATA-1:0]  result_q;
    logic                overflow_q, zero_q, negative_q;

    logic [NB_DATA-1:0]  sum, diff, aluResult, nextResult, mulProduct;
    logic                aluOverflow, nextOverflow, mulOverflow, mulDone;
    logic                isMul, shiftOver, mulStart, loadOut;

    assign sum       = i_data_a + i_data_b;
    assign diff      = i_data_a - i_data_b;
    assign shiftOver = (i_data_b >= SHIFT_LIMIT);
    assign isMul     = (i_operation_code == NB_OP'(OP_MUL));

    always_comb begin
        aluResult   = '0;
        aluOverflow = 1'b0;
        case (i_operation_code)
            NB_OP'(OP_ADD): begin
                aluResult   = sum;
                aluOverflow = (i_data_a[MSB] == i_data_b[MSB]) && (sum[MSB] != i_data_a[MSB]);
            end
            NB_OP'(OP_SUB): begin
                aluResult   = diff;
                aluOverflow = (i_data_a[MSB] != i_data_b[MSB]) && (diff[MSB] != i_data_a[MSB]);
            end
            NB_OP'(OP_AND): aluResult = i_data_a & i_data_b;
            NB_OP'(OP_OR):  aluResult = i_data_a | i_data_b;
            NB_OP'(OP_XOR): aluResult = i_data_a ^ i_data_b;
            NB_OP'(OP_NOR): aluResult = ~(i_data_a | i_data_b);
            NB_OP'(OP_SLT): aluResult = {{(NB_DATA-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
            NB_OP'(OP_SRL): aluResult = shiftOver ? '0 : (i_data_a >> i_data_b);
            NB_OP'(OP_SRA): aluResult = shiftOver ? {NB_DATA{i_data_a[MSB]}}
                                                  : NB_DATA'($signed(i_data_a) >>> i_data_b);
            default: ;
        endcase
    end

    alu_mul_seq #(
        .NB_DATA (NB_DATA)
    ) u_mul (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (mulStart),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .o_done     (mulDone),
        .o_product  (mulProduct),
        .o_overflow (mulOverflow)
    );

    // In IDLE o_ready is high, so i_valid alone means a transfer.
    always_comb begin
        state_d      = state_q;
        mulStart     = 1'b0;
        loadOut      = 1'b0;
        nextResult   = aluResult;
        nextOverflow = aluOverflow;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (isMul) begin
                        mulStart = 1'b1;
                        state_d  = MUL_BUSY;
                    end else begin
                        loadOut = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                nextResult   = mulProduct;
                nextOverflow = mulOverflow;
                if (mulDone) begin
                    loadOut = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= loadOut;
            if (loadOut) begin
                result_q   <= nextResult;
                overflow_q <= nextOverflow;
                zero_q     <= (nextResult == '0);
                negative_q <= nextResult[MSB];
            end
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_overflow = overflow_q;
    assign o_zero     = zero_q;
    assign o_negative = negative_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc (NB_DATA=8) against an integer
// arithmetic reference model.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data_a;
    logic [7:0] i_data_b;
    logic [5:0] i_operation_code;
    logic       o_valid;
    logic [7:0] o_result;
    logic       o_overflow;
    logic       o_zero;
    logic       o_negative;

    int checkCount = 0;
    int errorCount = 0;

    always #5 i_clk = ~i_clk;

    alu_mc #(
        .NB_DATA (8),
        .NB_OP   (6)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_data_a         (i_data_a),
        .i_data_b         (i_data_b),
        .i_operation_code (i_operation_code),
        .o_valid          (o_valid),
        .o_result         (o_result),
        .o_overflow       (o_overflow),
        .o_zero           (o_zero),
        .o_negative       (o_negative)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: signed integer arithmetic, overflow means the exact answer leaves [-128,127].
    function automatic void refModel(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] res, output logic ovf);
        int sa;
        int sb;
        int amt;
        int full;
        sa   = $signed(a);
        sb   = $signed(b);
        amt  = int'(b);
        full = 0;
        res  = 8'h00;
        ovf  = 1'b0;
        case (op)
            6'b100000: begin full = sa + sb; res = full[7:0]; ovf = (full > 127) || (full < -128); end
            6'b100010: begin full = sa - sb; res = full[7:0]; ovf = (full > 127) || (full < -128); end
            6'b011000: begin full = sa * sb; res = full[7:0]; ovf = (full > 127) || (full < -128); end
            6'b100100: res = a & b;
            6'b100101: res = a | b;
            6'b100110: res = a ^ b;
            6'b100111: res = ~(a | b);
            6'b101010: res = (sa < sb) ? 8'd1 : 8'd0;
            6'b000010: res = (amt >= 8) ? 8'h00 : (a >> amt);
            6'b000011: begin full = sa >>> ((amt > 31) ? 31 : amt); res = full[7:0]; end
            default: ;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where the result is visible.
    task automatic applyStimulus(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input bit holdAddWhileBusy);
        logic [7:0] expRes;
        logic       expOvf;
        int         waited;
        refModel(op, a, b, expRes, expOvf);
        checkOutput("readyIdle", o_ready, 1);
        i_valid          = 1'b1;
        i_operation_code = op;
        i_data_a         = a;
        i_data_b         = b;
        @(posedge i_clk);
        @(negedge i_clk);
        if (op == OP_MUL) begin
            if (holdAddWhileBusy) begin
                i_operation_code = OP_ADD;
                i_data_a         = 8'h11;
                i_data_b         = 8'h22;
            end else begin
                i_valid = 1'b0;
            end
            waited = 0;
            while (!o_valid && waited < 20) begin
                checkOutput("busyReady", o_ready, 0);
                @(negedge i_clk);
                waited++;
            end
            i_valid = 1'b0;
            checkOutput("mulLatency", waited, 8);
        end else begin
            i_valid = 1'b0;
        end
        checkOutput("outValid", o_valid, 1);
        checkOutput("readyAfter", o_ready, 1);
        checkOutput("result", o_result, expRes);
        checkOutput("overflow", o_overflow, expOvf);
        checkOutput("zero", o_zero, expRes == 8'h00);
        checkOutput("negative", o_negative, expRes[7]);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [5:0] opTable [10];
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         pulses;
        int         idx;

        opTable = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR, OP_SLT, OP_MUL};
        i_reset          = 1'b1;
        i_valid          = 1'b0;
        i_data_a         = 8'h00;
        i_data_b         = 8'h00;
        i_operation_code = 6'h00;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("rstReady", o_ready, 1);
        checkOutput("rstValid", o_valid, 0);
        checkOutput("rstResult", o_result, 0);
        checkOutput("rstOverflow", o_overflow, 0);
        checkOutput("rstZero", o_zero, 0);
        checkOutput("rstNegative", o_negative, 0);
        i_reset = 1'b0;
        @(negedge i_clk);

        applyStimulus(OP_ADD, 8'h7F, 8'h01, 1'b0);
        applyStimulus(OP_SUB, 8'h05, 8'h05, 1'b0);
        applyStimulus(OP_SRA, 8'h80, 8'd3, 1'b0);
        applyStimulus(OP_SRL, 8'h80, 8'd3, 1'b0);
        applyStimulus(OP_SRL, 8'h80, 8'd9, 1'b0);
        applyStimulus(OP_SRA, 8'h80, 8'd9, 1'b0);
        applyStimulus(OP_SLT, 8'hFF, 8'h01, 1'b0);
        applyStimulus(OP_MUL, 8'hFD, 8'h05, 1'b1);
        @(negedge i_clk);
        checkOutput("noStrayValid", o_valid, 0);
        checkOutput("heldMulResult", o_result, 8'hF1);
        applyStimulus(OP_MUL, 8'h10, 8'h08, 1'b0);
        applyStimulus(OP_MUL, 8'h80, 8'h01, 1'b0);
        applyStimulus(OP_MUL, 8'h80, 8'hFF, 1'b0);
        applyStimulus(6'h3F, 8'h12, 8'h34, 1'b0);

        // Back-to-back ADDs, one accepted per cycle.
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) begin
                checkOutput("b2bValid", o_valid, 1);
                checkOutput("b2bResult", o_result, 2 * (i - 1));
            end
            if (i <= 5) begin
                i_valid          = 1'b1;
                i_operation_code = OP_ADD;
                i_data_a         = 8'(i);
                i_data_b         = 8'(i);
            end else begin
                i_valid = 1'b0;
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end
        checkOutput("b2bEnd", o_valid, 0);

        // Reset in the middle of a multiply.
        applyStimulus(OP_ADD, 8'h7F, 8'h01, 1'b0);
        i_valid          = 1'b1;
        i_operation_code = OP_MUL;
        i_data_a         = 8'h7F;
        i_data_b         = 8'h03;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        checkOutput("midRstReady", o_ready, 1);
        checkOutput("midRstValid", o_valid, 0);
        checkOutput("midRstResult", o_result, 0);
        checkOutput("midRstOverflow", o_overflow, 0);
        checkOutput("midRstZero", o_zero, 0);
        checkOutput("midRstNegative", o_negative, 0);
        i_reset = 1'b0;
        pulses  = 0;
        repeat (15) begin
            @(negedge i_clk);
            if (o_valid) pulses++;
        end
        checkOutput("noValidAfterRst", pulses, 0);
        checkOutput("resultAfterRst", o_result, 0);

        for (int n = 0; n < 60; n++) begin
            idx = int'($urandom_range(0, 10));
            op  = (idx == 10) ? 6'($urandom) : opTable[idx];
            a   = 8'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            applyStimulus(op, a, b, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
